// File: rtl/wbslv_ahbmas_bridge_if.sv
// Bus bundle for the Wishbone-slave / AHB-master bridge: Wishbone request and
// response signals plus the AHB single-transfer master signals.
interface wbslv_ahbmas_bridge_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  localparam int SW = DWIDTH / 8;

  logic              cyc_i;
  logic              stb_i;
  logic              we_i;
  logic [SW-1:0]     sel_i;
  logic [AWIDTH-1:0] addr_i;
  logic [DWIDTH-1:0] data_i;
  logic [DWIDTH-1:0] data_o;
  logic              ack_o;
  logic              err_o;

  logic [AWIDTH-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic [DWIDTH-1:0] hwdata;
  logic [DWIDTH-1:0] hrdata;
  logic              hready;
  logic [1:0]        hresp;

  // Bridge view: Wishbone slave side plus AHB master side.
  modport slave (
    input  cyc_i, stb_i, we_i, sel_i, addr_i, data_i,
    output data_o, ack_o, err_o,
    output haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
    input  hrdata, hready, hresp
  );

  // Environment view: Wishbone master and AHB slave.
  modport master (
    output cyc_i, stb_i, we_i, sel_i, addr_i, data_i,
    input  data_o, ack_o, err_o,
    input  haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/wbslv_ahbmas_bridge.sv
// Wishbone-classic slave to AHB single-transfer master bridge with sel->HSIZE
// decode, two-cycle ERROR handling, bounded RETRY/SPLIT re-issue and watchdog.
module wbslv_ahbmas_bridge #(
  parameter int         AWIDTH    = 32,
  parameter int         DWIDTH    = 32,
  parameter int         RETRY_MAX = 4,
  parameter int         TIMEOUT   = 256,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  wbslv_ahbmas_bridge_if.slave bus
);
  localparam int unsigned SW  = DWIDTH / 8;
  localparam int unsigned SWL = $clog2(SW);
  localparam int unsigned RTW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam int unsigned WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [RTW-1:0] RMAX    = RTW'(RETRY_MAX);
  localparam logic [WDW-1:0] WD_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;

  localparam logic [1:0] HT_IDLE     = 2'b00;
  localparam logic [1:0] HT_NONSEQ   = 2'b10;
  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_ERR2, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        htrans_q, htrans_d;
  logic [AWIDTH-1:0] haddr_q, haddr_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hsize_q, hsize_d;
  logic [DWIDTH-1:0] hwdata_q, hwdata_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [RTW-1:0]    retry_q, retry_d;
  logic [WDW-1:0]    wdog_q, wdog_d;

  logic              sel_ok;
  logic [2:0]        sel_size;
  logic [SWL-1:0]    sel_off;
  logic [SW-1:0]     pat;
  logic              wd_hit;
  logic              fin, fin_err, fin_rd;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^bus.addr_i[SWL-1:0];
  assign wd_hit = (TIMEOUT != 0) && (wdog_q == WD_LAST);

  // Accept only naturally aligned groups of 2^s contiguous lanes.
  always_comb begin
    sel_ok   = 1'b0;
    sel_size = '0;
    sel_off  = '0;
    pat      = '0;
    for (int unsigned s = 0; s <= SWL; s++) begin
      for (int unsigned k = 0; k < SW; k++) begin
        if (k < (SW >> s)) begin
          for (int unsigned b = 0; b < SW; b++) begin
            pat[b] = (b >= (k << s)) && (b < ((k + 1) << s));
          end
          if (bus.sel_i == pat) begin
            sel_ok   = 1'b1;
            sel_size = 3'(s);
            sel_off  = SWL'(k << s);
          end
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    htrans_d = HT_IDLE;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hsize_d  = hsize_q;
    hwdata_d = hwdata_q;
    rdata_d  = rdata_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    retry_d  = retry_q;
    wdog_d   = wdog_q;
    fin      = 1'b0;
    fin_err  = 1'b0;
    fin_rd   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cyc_i && bus.stb_i) begin
          if (sel_ok) begin
            state_d  = S_ADDR;
            htrans_d = HT_NONSEQ;
            haddr_d  = {bus.addr_i[AWIDTH-1:SWL], sel_off};
            hwrite_d = bus.we_i;
            hsize_d  = sel_size;
            hwdata_d = bus.data_i;
            retry_d  = '0;
            wdog_d   = '0;
          end else begin
            state_d = S_RESP;
            err_d   = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (wd_hit) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          wdog_d = wdog_q + WDW'(1);
          if (bus.hready) state_d = S_DATA;
          else            htrans_d = HT_NONSEQ;
        end
      end
      S_DATA: begin
        if (wd_hit) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          wdog_d = wdog_q + WDW'(1);
          if (bus.hresp == HRESP_ERROR) begin
            if (bus.hready) begin
              fin     = 1'b1;
              fin_err = 1'b1;
            end else begin
              state_d = S_ERR2;
            end
          end else if (bus.hready) begin
            if (bus.hresp == HRESP_OKAY) begin
              fin    = 1'b1;
              fin_rd = ~hwrite_q;
            end else if (retry_q < RMAX) begin
              // RETRY/SPLIT second cycle: re-issue the same address phase.
              state_d  = S_ADDR;
              htrans_d = HT_NONSEQ;
              retry_d  = retry_q + RTW'(1);
              wdog_d   = '0;
            end else begin
              fin     = 1'b1;
              fin_err = 1'b1;
            end
          end
        end
      end
      S_ERR2: begin
        if (wd_hit || bus.hready) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A master that has dropped cyc_i gets no termination; the AHB side still completes.
    if (fin) begin
      state_d = bus.cyc_i ? S_RESP : S_IDLE;
      ack_d   = bus.cyc_i & ~fin_err;
      err_d   = bus.cyc_i & fin_err;
      if (fin_rd && bus.cyc_i) rdata_d = bus.hrdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      htrans_q <= HT_IDLE;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hsize_q  <= 3'b010;
      hwdata_q <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      retry_q  <= '0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      htrans_q <= htrans_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      hsize_q  <= hsize_d;
      hwdata_q <= hwdata_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      retry_q  <= retry_d;
      wdog_q   <= wdog_d;
    end
  end

  assign bus.htrans = htrans_q;
  assign bus.haddr  = haddr_q;
  assign bus.hwrite = hwrite_q;
  assign bus.hsize  = hsize_q;
  assign bus.hburst = 3'b000;
  assign bus.hprot  = HPROT_VAL;
  assign bus.hwdata = hwdata_q;
  assign bus.data_o = rdata_q;
  assign bus.ack_o  = ack_q;
  assign bus.err_o  = err_q;
endmodule

// File: tb/tb_wbslv_ahbmas_bridge.sv
// Directed bench for wbslv_ahbmas_bridge: a 32-bit instance (RETRY_MAX=2,
// TIMEOUT=8) and a 64-bit instance for the wide lane decode.
module tb_wbslv_ahbmas_bridge;
  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  wbslv_ahbmas_bridge_if #(.AWIDTH(32), .DWIDTH(32)) bus32 ();
  wbslv_ahbmas_bridge_if #(.AWIDTH(32), .DWIDTH(64)) bus64 ();

  wbslv_ahbmas_bridge #(.AWIDTH(32), .DWIDTH(32), .RETRY_MAX(2), .TIMEOUT(8),
                        .HPROT_VAL(4'b0011))
    dut32 (.clk_i(clk), .rst_i(rst), .bus(bus32));

  wbslv_ahbmas_bridge #(.AWIDTH(32), .DWIDTH(64), .RETRY_MAX(4), .TIMEOUT(16),
                        .HPROT_VAL(4'b0011))
    dut64 (.clk_i(clk), .rst_i(rst), .bus(bus64));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus32.cyc_i = 1'b0; bus32.stb_i = 1'b0; bus32.we_i = 1'b0; bus32.sel_i = '0;
    bus32.addr_i = '0; bus32.data_i = '0; bus32.hrdata = '0; bus32.hready = 1'b1;
    bus32.hresp = 2'b00;
    bus64.cyc_i = 1'b0; bus64.stb_i = 1'b0; bus64.we_i = 1'b0; bus64.sel_i = '0;
    bus64.addr_i = '0; bus64.data_i = '0; bus64.hrdata = '0; bus64.hready = 1'b1;
    bus64.hresp = 2'b00;
  endtask

  task automatic req32(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                       input logic [31:0] wdata);
    bus32.cyc_i = 1'b1; bus32.stb_i = 1'b1; bus32.we_i = we; bus32.sel_i = sel;
    bus32.addr_i = addr; bus32.data_i = wdata;
  endtask

  task automatic drop32();
    bus32.cyc_i = 1'b0; bus32.stb_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_bus();
    tick(); tick();
    tests_run++; if (bus32.htrans !== 2'b00) begin tests_failed++; $display("FAIL rst_htrans: got %b want 00", bus32.htrans); end
    tests_run++; if (bus32.haddr !== 32'h0) begin tests_failed++; $display("FAIL rst_haddr: got %h want 0", bus32.haddr); end
    tests_run++; if (bus32.hwrite !== 1'b0) begin tests_failed++; $display("FAIL rst_hwrite: got %b want 0", bus32.hwrite); end
    tests_run++; if (bus32.hsize !== 3'b010) begin tests_failed++; $display("FAIL rst_hsize: got %b want 010", bus32.hsize); end
    tests_run++; if (bus32.hburst !== 3'b000) begin tests_failed++; $display("FAIL rst_hburst: got %b want 000", bus32.hburst); end
    tests_run++; if (bus32.hprot !== 4'b0011) begin tests_failed++; $display("FAIL rst_hprot: got %b want 0011", bus32.hprot); end
    tests_run++; if (bus32.hwdata !== 32'h0) begin tests_failed++; $display("FAIL rst_hwdata: got %h want 0", bus32.hwdata); end
    tests_run++; if (bus32.data_o !== 32'h0) begin tests_failed++; $display("FAIL rst_data_o: got %h want 0", bus32.data_o); end
    tests_run++; if ({bus32.ack_o, bus32.err_o} !== 2'b00) begin tests_failed++; $display("FAIL rst_ack_err: got %b want 00", {bus32.ack_o, bus32.err_o}); end
    tests_run++; if (bus64.hsize !== 3'b010) begin tests_failed++; $display("FAIL rst_hsize64: got %b want 010", bus64.hsize); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero_wait_read();
    bus32.hrdata = 32'hDEADBEEF; bus32.hready = 1'b1; bus32.hresp = 2'b00;
    req32(1'b0, 4'hF, 32'h0000_1000, 32'h0);
    tick();
    tests_run++; if (bus32.htrans !== 2'b10) begin tests_failed++; $display("FAIL zw_htrans: got %b want 10", bus32.htrans); end
    tests_run++; if (bus32.haddr !== 32'h0000_1000) begin tests_failed++; $display("FAIL zw_haddr: got %h want 00001000", bus32.haddr); end
    tests_run++; if (bus32.hsize !== 3'b010) begin tests_failed++; $display("FAIL zw_hsize: got %b want 010", bus32.hsize); end
    tests_run++; if (bus32.hwrite !== 1'b0) begin tests_failed++; $display("FAIL zw_hwrite: got %b want 0", bus32.hwrite); end
    tick();
    tests_run++; if (bus32.htrans !== 2'b00) begin tests_failed++; $display("FAIL zw_data_htrans: got %b want 00", bus32.htrans); end
    tick();
    tests_run++; if (bus32.ack_o !== 1'b1) begin tests_failed++; $display("FAIL zw_ack: got %b want 1", bus32.ack_o); end
    tests_run++; if (bus32.data_o !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL zw_data_o: got %h want deadbeef", bus32.data_o); end
    drop32();
    tick();
    tests_run++; if (bus32.ack_o !== 1'b0) begin tests_failed++; $display("FAIL zw_ack_pulse: got %b want 0", bus32.ack_o); end
  endtask

  task automatic test_wait_write();
    bus32.hready = 1'b1; bus32.hresp = 2'b00;
    req32(1'b1, 4'b0100, 32'h0000_2000, 32'h00AB_0000);
    tick();
    tests_run++; if (bus32.haddr !== 32'h0000_2002) begin tests_failed++; $display("FAIL ww_haddr: got %h want 00002002", bus32.haddr); end
    tests_run++; if (bus32.hsize !== 3'b000) begin tests_failed++; $display("FAIL ww_hsize: got %b want 000", bus32.hsize); end
    tests_run++; if (bus32.hwrite !== 1'b1) begin tests_failed++; $display("FAIL ww_hwrite: got %b want 1", bus32.hwrite); end
    tick();
    bus32.hready = 1'b0;
    tests_run++; if (bus32.hwdata !== 32'h00AB_0000) begin tests_failed++; $display("FAIL ww_hwdata: got %h want 00ab0000", bus32.hwdata); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if ({bus32.ack_o, bus32.err_o} !== 2'b00) begin tests_failed++; $display("FAIL ww_wait_term: cycle %0d got %b want 00", i + 3, {bus32.ack_o, bus32.err_o}); end
    end
    bus32.hready = 1'b1;
    tick();
    tests_run++; if ({bus32.ack_o, bus32.err_o} !== 2'b10) begin tests_failed++; $display("FAIL ww_ack_c6: got %b want 10", {bus32.ack_o, bus32.err_o}); end
    drop32();
    tick();
  endtask

  task automatic test_error();
    bus32.hready = 1'b1; bus32.hresp = 2'b00;
    req32(1'b0, 4'hF, 32'h0000_3000, 32'h0);
    tick();
    tick();
    bus32.hresp = 2'b01; bus32.hready = 1'b0;
    tick();
    tests_run++; if ({bus32.ack_o, bus32.err_o} !== 2'b00) begin tests_failed++; $display("FAIL er_err2_term: got %b want 00", {bus32.ack_o, bus32.err_o}); end
    bus32.hready = 1'b1;
    tick();
    tests_run++; if ({bus32.ack_o, bus32.err_o} !== 2'b01) begin tests_failed++; $display("FAIL er_err: got %b want 01", {bus32.ack_o, bus32.err_o}); end
    bus32.hresp = 2'b00;
    drop32();
    tick();
    tests_run++; if (bus32.err_o !== 1'b0) begin tests_failed++; $display("FAIL er_err_pulse: got %b want 0", bus32.err_o); end
  endtask

  task automatic test_retry_bounds();
    bit       hr_a [9] = '{1, 0, 1, 1, 0, 1, 1, 0, 1};
    bit [1:0] rs_a [9] = '{0, 2, 2, 0, 2, 2, 0, 2, 2};
    bit       hr_b [5] = '{1, 0, 1, 1, 1};
    bit [1:0] rs_b [5] = '{0, 3, 3, 0, 0};
    int nonseq;
    int early;
    int badaddr;

    nonseq = 0; early = 0; badaddr = 0;
    bus32.hready = 1'b1; bus32.hresp = 2'b00;
    req32(1'b0, 4'hF, 32'h0000_4000, 32'h0);
    for (int i = 0; i < 9; i++) begin
      tick();
      if (bus32.htrans == 2'b10) begin
        nonseq++;
        if (bus32.haddr != 32'h0000_4000) badaddr++;
      end
      if (bus32.ack_o || bus32.err_o) early++;
      bus32.hready = hr_a[i]; bus32.hresp = rs_a[i];
    end
    tick();
    tests_run++; if (nonseq !== 3) begin tests_failed++; $display("FAIL rt_nonseq: got %0d want 3", nonseq); end
    tests_run++; if (badaddr !== 0) begin tests_failed++; $display("FAIL rt_haddr: got %0d bad phases want 0", badaddr); end
    tests_run++; if (early !== 0) begin tests_failed++; $display("FAIL rt_early_term: got %0d want 0", early); end
    tests_run++; if ({bus32.ack_o, bus32.err_o} !== 2'b01) begin tests_failed++; $display("FAIL rt_err: got %b want 01", {bus32.ack_o, bus32.err_o}); end
    bus32.hresp = 2'b00; bus32.hready = 1'b1;
    drop32();
    tick();

    nonseq = 0;
    bus32.hrdata = 32'h1234_5678;
    req32(1'b0, 4'hF, 32'h0000_4100, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus32.htrans == 2'b10) nonseq++;
      bus32.hready = hr_b[i]; bus32.hresp = rs_b[i];
    end
    tick();
    tests_run++; if (nonseq !== 2) begin tests_failed++; $display("FAIL rt2_nonseq: got %0d want 2", nonseq); end
    tests_run++; if ({bus32.ack_o, bus32.err_o} !== 2'b10) begin tests_failed++; $display("FAIL rt2_ack: got %b want 10", {bus32.ack_o, bus32.err_o}); end
    tests_run++; if (bus32.data_o !== 32'h1234_5678) begin tests_failed++; $display("FAIL rt2_data_o: got %h want 12345678", bus32.data_o); end
    drop32();
    tick();
  endtask

  task automatic test_sel_decode();
    bus32.hready = 1'b1; bus32.hresp = 2'b00;
    req32(1'b0, 4'b0110, 32'h0000_5000, 32'h0);
    tick();
    tests_run++; if (bus32.err_o !== 1'b1) begin tests_failed++; $display("FAIL sel0110_err: got %b want 1", bus32.err_o); end
    tests_run++; if (bus32.htrans !== 2'b00) begin tests_failed++; $display("FAIL sel0110_htrans: got %b want 00", bus32.htrans); end
    drop32();
    tick();
    req32(1'b0, 4'b0000, 32'h0000_5000, 32'h0);
    tick();
    tests_run++; if ({bus32.err_o, bus32.htrans} !== 3'b100) begin tests_failed++; $display("FAIL sel0000_err: got %b want 100", {bus32.err_o, bus32.htrans}); end
    drop32();
    tick();
    req32(1'b0, 4'b1100, 32'h0000_5001, 32'h0);
    tick();
    tests_run++; if (bus32.haddr !== 32'h0000_5002) begin tests_failed++; $display("FAIL sel1100_haddr: got %h want 00005002", bus32.haddr); end
    tests_run++; if (bus32.hsize !== 3'b001) begin tests_failed++; $display("FAIL sel1100_hsize: got %b want 001", bus32.hsize); end
    tick(); tick();
    tests_run++; if (bus32.ack_o !== 1'b1) begin tests_failed++; $display("FAIL sel1100_ack: got %b want 1", bus32.ack_o); end
    drop32();
    tick();
  endtask

  task automatic test_timeout();
    int    nonseq;
    bit    got;
    logic [1:0] htr;
    nonseq = 0; got = 1'b0; htr = 2'b11;
    bus32.hready = 1'b0; bus32.hresp = 2'b00;
    req32(1'b1, 4'hF, 32'h0000_9000, 32'h5555_AAAA);
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (bus32.err_o) begin
        got = 1'b1;
        htr = bus32.htrans;
      end else if (bus32.htrans == 2'b10) begin
        nonseq++;
      end
    end
    tests_run++; if (got !== 1'b1) begin tests_failed++; $display("FAIL to_err_seen: got %b want 1", got); end
    tests_run++; if (nonseq !== 8) begin tests_failed++; $display("FAIL to_addr_cycles: got %0d want 8", nonseq); end
    tests_run++; if (htr !== 2'b00) begin tests_failed++; $display("FAIL to_htrans_at_err: got %b want 00", htr); end
    bus32.hready = 1'b1;
    drop32();
    tick();
    tests_run++; if ({bus32.ack_o, bus32.err_o, bus32.htrans} !== 4'b0000) begin tests_failed++; $display("FAIL to_late_ready: got %b want 0000", {bus32.ack_o, bus32.err_o, bus32.htrans}); end
  endtask

  task automatic test_cyc_drop();
    bus32.hready = 1'b1; bus32.hresp = 2'b00; bus32.hrdata = 32'h0BAD_CAFE;
    req32(1'b0, 4'hF, 32'h0000_8000, 32'h0);
    tick();
    tick();
    drop32();
    tick();
    tests_run++; if ({bus32.ack_o, bus32.err_o} !== 2'b00) begin tests_failed++; $display("FAIL cd_no_term: got %b want 00", {bus32.ack_o, bus32.err_o}); end
    req32(1'b0, 4'hF, 32'h0000_8004, 32'h0);
    tick();
    tests_run++; if (bus32.htrans !== 2'b10) begin tests_failed++; $display("FAIL cd_idle_reissue: got %b want 10", bus32.htrans); end
    tests_run++; if (bus32.haddr !== 32'h0000_8004) begin tests_failed++; $display("FAIL cd_haddr: got %h want 00008004", bus32.haddr); end
    tick(); tick();
    tests_run++; if (bus32.ack_o !== 1'b1) begin tests_failed++; $display("FAIL cd_ack: got %b want 1", bus32.ack_o); end
    drop32();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] acks;
    acks = '0;
    bus32.hready = 1'b1; bus32.hresp = 2'b00; bus32.hrdata = 32'h1111_2222;
    req32(1'b0, 4'hF, 32'h0000_A000, 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      acks[i] = bus32.ack_o;
    end
    drop32();
    tests_run++; if (acks !== 8'b0100_0100) begin tests_failed++; $display("FAIL b2b_ack_pattern: got %b want 01000100", acks); end
    tests_run++; if (bus32.data_o !== 32'h1111_2222) begin tests_failed++; $display("FAIL b2b_data_o: got %h want 11112222", bus32.data_o); end
    tick();
  endtask

  task automatic test_reset_in_data();
    bus32.hready = 1'b1; bus32.hresp = 2'b00;
    req32(1'b1, 4'hF, 32'h0000_6000, 32'hCAFE_F00D);
    tick();
    tick();
    bus32.hready = 1'b0;
    rst = 1'b1;
    tick();
    tests_run++; if (bus32.htrans !== 2'b00) begin tests_failed++; $display("FAIL rd_htrans: got %b want 00", bus32.htrans); end
    tests_run++; if (bus32.haddr !== 32'h0) begin tests_failed++; $display("FAIL rd_haddr: got %h want 0", bus32.haddr); end
    tests_run++; if ({bus32.hwrite, bus32.hsize} !== 4'b0010) begin tests_failed++; $display("FAIL rd_hwrite_hsize: got %b want 0010", {bus32.hwrite, bus32.hsize}); end
    tests_run++; if (bus32.hwdata !== 32'h0) begin tests_failed++; $display("FAIL rd_hwdata: got %h want 0", bus32.hwdata); end
    tests_run++; if (bus32.data_o !== 32'h0) begin tests_failed++; $display("FAIL rd_data_o: got %h want 0", bus32.data_o); end
    tests_run++; if ({bus32.ack_o, bus32.err_o} !== 2'b00) begin tests_failed++; $display("FAIL rd_ack_err: got %b want 00", {bus32.ack_o, bus32.err_o}); end
    rst = 1'b0;
    drop32();
    bus32.hready = 1'b1;
    tick();
    tests_run++; if ({bus32.ack_o, bus32.err_o, bus32.htrans} !== 4'b0000) begin tests_failed++; $display("FAIL rd_abandoned: got %b want 0000", {bus32.ack_o, bus32.err_o, bus32.htrans}); end
  endtask

  task automatic test_wide();
    bus64.hready = 1'b1; bus64.hresp = 2'b00;
    bus64.cyc_i = 1'b1; bus64.stb_i = 1'b1; bus64.we_i = 1'b1; bus64.sel_i = 8'hFF;
    bus64.addr_i = 32'h0000_700C; bus64.data_i = 64'h0123_4567_89AB_CDEF;
    tick();
    tests_run++; if (bus64.haddr !== 32'h0000_7008) begin tests_failed++; $display("FAIL w64_ff_haddr: got %h want 00007008", bus64.haddr); end
    tests_run++; if (bus64.hsize !== 3'b011) begin tests_failed++; $display("FAIL w64_ff_hsize: got %b want 011", bus64.hsize); end
    tick();
    tests_run++; if (bus64.hwdata !== 64'h0123_4567_89AB_CDEF) begin tests_failed++; $display("FAIL w64_hwdata: got %h want 0123456789abcdef", bus64.hwdata); end
    tick();
    tests_run++; if (bus64.ack_o !== 1'b1) begin tests_failed++; $display("FAIL w64_ff_ack: got %b want 1", bus64.ack_o); end
    bus64.cyc_i = 1'b0; bus64.stb_i = 1'b0;
    tick();
    bus64.cyc_i = 1'b1; bus64.stb_i = 1'b1; bus64.we_i = 1'b0; bus64.sel_i = 8'h30;
    bus64.addr_i = 32'h0000_7000;
    tick();
    tests_run++; if (bus64.haddr !== 32'h0000_7004) begin tests_failed++; $display("FAIL w64_30_haddr: got %h want 00007004", bus64.haddr); end
    tests_run++; if (bus64.hsize !== 3'b001) begin tests_failed++; $display("FAIL w64_30_hsize: got %b want 001", bus64.hsize); end
    tick(); tick();
    bus64.cyc_i = 1'b0; bus64.stb_i = 1'b0;
    tick();
    bus64.cyc_i = 1'b1; bus64.stb_i = 1'b1; bus64.sel_i = 8'h18;
    tick();
    tests_run++; if ({bus64.err_o, bus64.htrans} !== 3'b100) begin tests_failed++; $display("FAIL w64_18_err: got %b want 100", {bus64.err_o, bus64.htrans}); end
    bus64.cyc_i = 1'b0; bus64.stb_i = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_zero_wait_read();
    test_wait_write();
    test_error();
    test_retry_bounds();
    test_sel_decode();
    test_timeout();
    test_cyc_drop();
    test_back_to_back();
    test_reset_in_data();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
